// File: rtl/pwm_fade_ctrl.sv
// Breathing-profile sequencer for a PWM timer. It ramps the compare value up,
// holds it high, ramps it down and holds it low, moving one step per timer period.
module pwm_fade_ctrl #(
  parameter int size   = 24,
  parameter int hold_w = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [size-1:0]   period_in,
  input  logic [size-1:0]   step_in,
  input  logic [hold_w-1:0] hold_periods,
  input  logic [size-1:0]   tmr_count,
  output logic [size-1:0]   tmr_period,
  output logic [size-1:0]   tmr_compare,
  output logic [2:0]        state,
  output logic              busy,
  output logic              cycle_done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RAMP_UP = 3'd1,
    HOLD_HI = 3'd2,
    RAMP_DN = 3'd3,
    HOLD_LO = 3'd4
  } state_t;

  localparam logic [hold_w:0] hold_one = (hold_w+1)'(1);

  state_t            state_reg;
  logic [hold_w-1:0] hold_cnt;
  logic [size-1:0]   step_lat;

  logic              tick;
  logic [size:0]     up_sum;
  logic              hold_done;
  logic [size-1:0]   step_eff;

  // The timer restarts its count at zero once per period; that is our tick.
  assign tick      = (tmr_count == '0);
  assign up_sum    = {1'b0, tmr_compare} + {1'b0, step_lat};
  assign hold_done = (({1'b0, hold_cnt} + hold_one) >= {1'b0, hold_periods});
  // A zero step would freeze the ramp forever, so it is promoted to one.
  assign step_eff  = (step_in == '0) ? size'(1) : step_in;
  assign state     = state_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      tmr_period  <= '0;
      tmr_compare <= '0;
      busy        <= 1'b0;
      cycle_done  <= 1'b0;
      hold_cnt    <= '0;
      step_lat    <= '0;
    end else begin
      cycle_done <= 1'b0;
      case (state_reg)
        IDLE: begin
          tmr_compare <= '0;
          if (enable) begin
            tmr_period <= period_in;
            step_lat   <= step_eff;
            hold_cnt   <= '0;
            state_reg  <= RAMP_UP;
            busy       <= 1'b1;
          end
        end

        RAMP_UP: begin
          if (tick) begin
            // Sum is one bit wider so a large step clamps instead of wrapping.
            if (up_sum >= {1'b0, tmr_period}) begin
              tmr_compare <= tmr_period;
              hold_cnt    <= '0;
              state_reg   <= HOLD_HI;
            end else begin
              tmr_compare <= up_sum[size-1:0];
            end
          end
        end

        HOLD_HI: begin
          if (tick) begin
            if (hold_done) begin
              hold_cnt  <= '0;
              state_reg <= RAMP_DN;
            end else begin
              hold_cnt <= hold_cnt + hold_w'(1);
            end
          end
        end

        RAMP_DN: begin
          if (tick) begin
            if (tmr_compare <= step_lat) begin
              tmr_compare <= '0;
              hold_cnt    <= '0;
              state_reg   <= HOLD_LO;
            end else begin
              tmr_compare <= tmr_compare - step_lat;
            end
          end
        end

        HOLD_LO: begin
          if (tick) begin
            if (hold_done) begin
              hold_cnt   <= '0;
              cycle_done <= 1'b1;
              // enable is only consulted here and in IDLE, so stopping is graceful.
              if (enable) begin
                tmr_period <= period_in;
                step_lat   <= step_eff;
                state_reg  <= RAMP_UP;
              end else begin
                state_reg <= IDLE;
                busy      <= 1'b0;
              end
            end else begin
              hold_cnt <= hold_cnt + hold_w'(1);
            end
          end
        end

        default: begin
          state_reg   <= IDLE;
          tmr_compare <= '0;
          hold_cnt    <= '0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Scoreboard bench for pwm_fade_ctrl: a plan-based reference model queues the
// expected outputs per clock edge and a monitor compares them on the falling edge.
module tb_pwm_fade_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [23:0] period_in;
  logic [23:0] step_in;
  logic [7:0]  hold_periods;
  logic [23:0] tmr_count;
  logic [23:0] tmr_period;
  logic [23:0] tmr_compare;
  logic [2:0]  state;
  logic        busy;
  logic        cycle_done;

  pwm_fade_ctrl #(.size(24), .hold_w(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .period_in    (period_in),
    .step_in      (step_in),
    .hold_periods (hold_periods),
    .tmr_count    (tmr_count),
    .tmr_period   (tmr_period),
    .tmr_compare  (tmr_compare),
    .state        (state),
    .busy         (busy),
    .cycle_done   (cycle_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  st;
    logic [23:0] per;
    logic [23:0] cmp;
    logic        bsy;
    logic        done;
  } exp_t;

  typedef struct {
    logic [2:0]  st;
    logic [23:0] cmp;
  } plan_t;

  exp_t  exp_q[$];
  plan_t plan[$];

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [2:0]  m_st  = 3'd0;
  logic [23:0] m_per = 24'd0;
  logic [23:0] m_cmp = 24'd0;
  logic        m_done = 1'b0;

  // timer environment
  bit      tmode = 1'b1;
  longint  cnt   = 0;

  // One whole breathing cycle is laid out as the (state, compare) reached
  // after each successive tick; the tick after the last entry ends the cycle.
  task automatic start_seq();
    longint p, s, v, c;
    int h;
    p = period_in;
    s = (step_in == 0) ? 1 : step_in;
    h = (hold_periods == 0) ? 1 : int'(hold_periods);
    m_per = period_in;
    m_st  = 3'd1;
    m_cmp = 24'd0;
    plan.delete();
    v = s;
    while (v < p) begin
      plan.push_back('{3'd1, 24'(v)});
      v += s;
    end
    for (int i = 0; i < h; i++) plan.push_back('{3'd2, 24'(p)});
    plan.push_back('{3'd3, 24'(p)});
    c = p;
    while (c > s) begin
      c -= s;
      plan.push_back('{3'd3, 24'(c)});
    end
    for (int i = 0; i < h; i++) plan.push_back('{3'd4, 24'd0});
  endtask

  task automatic model_edge();
    plan_t e;
    exp_t  x;
    m_done = 1'b0;
    if (rst) begin
      m_st = 3'd0; m_per = 24'd0; m_cmp = 24'd0;
      plan.delete();
    end else if (m_st == 3'd0) begin
      if (enable) start_seq();
    end else if (tmr_count == 24'd0) begin
      if (plan.size() == 0) begin
        m_done = 1'b1;
        if (enable) start_seq();
        else begin
          m_st = 3'd0; m_cmp = 24'd0;
        end
      end else begin
        e = plan.pop_front();
        m_st  = e.st;
        m_cmp = e.cmp;
      end
    end
    x.st = m_st; x.per = m_per; x.cmp = m_cmp;
    x.bsy = (m_st != 3'd0); x.done = m_done;
    exp_q.push_back(x);
  endtask

  // One clock: model the edge, then advance the timer stimulus.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    if (tmode) begin
      cnt = (cnt >= longint'(m_per)) ? 0 : cnt + 1;
      tmr_count = 24'(cnt);
    end else begin
      tmr_count = ($urandom_range(0, 2) == 0) ? 24'd0 : 24'($urandom_range(1, 15));
    end
  endtask

  // Reset is asynchronous: the outputs must already be cleared before the
  // next edge, so the expectation for the current cycle is replaced.
  task automatic async_rst();
    rst = 1'b1;
    m_st = 3'd0; m_per = 24'd0; m_cmp = 24'd0; m_done = 1'b0;
    plan.delete();
    exp_q[exp_q.size()-1] = '{3'd0, 24'd0, 24'd0, 1'b0, 1'b0};
  endtask

  task automatic wait_st(input logic [2:0] s, input int lim, input string nm);
    int n = 0;
    while (m_st != s && n < lim) begin
      cycle();
      n++;
    end
    if (m_st != s) begin
      total++;
      bad++;
      $display("FAIL %s: timeout, state %0d after %0d cycles, required %0d", nm, m_st, n, s);
    end
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic go_idle();
    enable = 1'b0;
    wait_st(3'd0, 2000, "go_idle");
  endtask

  function automatic void chk(input string nm, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s at %0t: got %0d, required %0d", nm, $time, act, req);
    end
  endfunction

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("state",       state,       e.st);
        chk("tmr_period",  tmr_period,  e.per);
        chk("tmr_compare", tmr_compare, e.cmp);
        chk("busy",        busy,        e.bsy);
        chk("cycle_done",  cycle_done,  e.done);
      end
    end
  end

  initial begin
    rst = 1'b1; enable = 1'b1; period_in = 24'd9; step_in = 24'd3;
    hold_periods = 8'd2; tmr_count = 24'd0;

    // reset held with enable high, then full profile P=9 step=3 hold=2
    run(3);
    rst = 1'b0;
    run(130);
    go_idle();

    // step zero promoted to one
    period_in = 24'd5; step_in = 24'd0; hold_periods = 8'd1; enable = 1'b1;
    run(60);
    go_idle();

    // step larger than period, hold zero
    period_in = 24'd5; step_in = 24'd7; hold_periods = 8'd0; enable = 1'b1;
    run(40);
    go_idle();

    // graceful stop during ramp up
    period_in = 24'd9; step_in = 24'd3; hold_periods = 8'd2; enable = 1'b1;
    run(5);
    enable = 1'b0;
    wait_st(3'd0, 500, "graceful_stop");
    run(5);

    // relatch: period change mid ramp down only lands at the HOLD_LO exit
    enable = 1'b1;
    wait_st(3'd3, 500, "reach_ramp_dn");
    period_in = 24'd19;
    wait_st(3'd4, 500, "reach_hold_lo");
    run(120);
    go_idle();

    // asynchronous reset during HOLD_HI
    period_in = 24'd9; step_in = 24'd3; hold_periods = 8'd3; enable = 1'b1;
    wait_st(3'd2, 500, "reach_hold_hi");
    cycle();
    async_rst();
    run(2);
    rst = 1'b0;
    run(30);

    // randomized phases
    for (int ph = 0; ph < 6; ph++) begin
      go_idle();
      hold_periods = 8'($urandom_range(0, 3));
      tmode = ($urandom_range(0, 1) == 1);
      enable = 1'b1;
      repeat (400) begin
        cycle();
        if ($urandom_range(0, 19) == 0) enable = ~enable;
        period_in = 24'($urandom_range(0, 12));
        step_in   = 24'($urandom_range(0, 6));
        if ($urandom_range(0, 299) == 0) begin
          async_rst();
          cycle();
          rst = 1'b0;
        end
      end
    end

    go_idle();
    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
